// File: rtl/rtc_edit_pkg.sv
// Shared types and constants for the RTC field editor.
// Field indices follow the RTC register order: date/time fields first, then the timer fields.
package rtc_edit_pkg;

    localparam int unsigned NUM_FIELDS_DEFAULT = 9;

    localparam int unsigned FLD_SEC      = 0;
    localparam int unsigned FLD_MIN      = 1;
    localparam int unsigned FLD_HOUR     = 2;
    localparam int unsigned FLD_DAY      = 3;
    localparam int unsigned FLD_MONTH    = 4;
    localparam int unsigned FLD_YEAR     = 5;
    localparam int unsigned FLD_TMR_SEC  = 6;
    localparam int unsigned FLD_TMR_MIN  = 7;
    localparam int unsigned FLD_TMR_HOUR = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        HOLD = 2'd2
    } edit_state_e;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for one debounced, already-synchronous button level.
// The stored copy resets to 0. rise_c_o is combinational: it is high while the
// live level is 1 and the stored copy is still 0.
module btn_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic rise_c_o
);

    logic btn_q;

    // Keep the previous button level.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_i;
        end
    end

    assign rise_c_o = btn_i & ~btn_q;

endmodule

// File: rtl/rtc_field_editor.sv
// RTC field editor: turns four debounced buttons into per-field inc/dec pulses.
// LEFT/RIGHT move the active field with wrap-around. UP/DOWN issue one pulse per press.
// Define RTC_FIELD_EDIT_AUTOREPEAT_EN to add hold-to-repeat, timed by
// REPEAT_DELAY and REPEAT_PERIOD.
module rtc_field_editor
    import rtc_edit_pkg::*;
#(
    parameter int unsigned NUM_FIELDS    = NUM_FIELDS_DEFAULT,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          btn_left,
    input  logic                          btn_right,
    output logic [$clog2(NUM_FIELDS)-1:0] field_sel,
    output logic [NUM_FIELDS-1:0]         inc_pulse,
    output logic [NUM_FIELDS-1:0]         dec_pulse,
    output logic                          editing,
    output logic                          commit
);

    localparam int unsigned SEL_W = $clog2(NUM_FIELDS);
    localparam logic [SEL_W-1:0] LAST_FIELD = SEL_W'(NUM_FIELDS - 1);

    // A zero repeat timing has no meaning; refuse to elaborate with one.
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat_cfg
        $error("rtc_field_editor: REPEAT_DELAY and REPEAT_PERIOD must be nonzero");
    end

    edit_state_e           state_q;
    logic [SEL_W-1:0]      field_sel_q;
    logic [NUM_FIELDS-1:0] inc_pulse_q;
    logic [NUM_FIELDS-1:0] dec_pulse_q;
    logic                  editing_q;
    logic                  commit_q;
    logic                  hold_down_q;

    logic up_rise_c, down_rise_c, left_rise_c, right_rise_c;
    logic still_held_c;
    logic rpt_fire_c;

    function automatic logic [NUM_FIELDS-1:0] field_onehot(input logic [SEL_W-1:0] idx);
        field_onehot = NUM_FIELDS'(1) << idx;
    endfunction

    btn_edge_detect u_edge_up    (.clock(clock), .reset(reset), .btn_i(btn_up),    .rise_c_o(up_rise_c));
    btn_edge_detect u_edge_down  (.clock(clock), .reset(reset), .btn_i(btn_down),  .rise_c_o(down_rise_c));
    btn_edge_detect u_edge_left  (.clock(clock), .reset(reset), .btn_i(btn_left),  .rise_c_o(left_rise_c));
    btn_edge_detect u_edge_right (.clock(clock), .reset(reset), .btn_i(btn_right), .rise_c_o(right_rise_c));

    // Release of the button that opened the hold is judged on its live level.
    assign still_held_c = hold_down_q ? btn_down : btn_up;

`ifdef RTC_FIELD_EDIT_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q;
    logic             rpt_armed_q;

    // Repeat is due when the hold has lasted the initial delay, then each period.
    assign rpt_fire_c = (state_q == HOLD) && en && still_held_c &&
                        (rpt_cnt_q == (rpt_armed_q ? PERIOD_LAST : DELAY_LAST));

    // Cycle counter since the last pulse of the current hold; saturates, never wraps.
    always_ff @(posedge clock) begin
        if (reset || state_q != HOLD) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else if (rpt_fire_c) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b1;
        end else if (rpt_cnt_q != '1) begin
            rpt_cnt_q <= rpt_cnt_q + CNT_W'(1);
        end
    end
`else
    assign rpt_fire_c = 1'b0;
`endif

    // Edit-mode state machine with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            field_sel_q <= '0;
            inc_pulse_q <= '0;
            dec_pulse_q <= '0;
            editing_q   <= 1'b0;
            commit_q    <= 1'b0;
            hold_down_q <= 1'b0;
        end else begin
            inc_pulse_q <= '0;
            dec_pulse_q <= '0;
            commit_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q     <= EDIT;
                        field_sel_q <= '0;
                        editing_q   <= 1'b1;
                    end
                end
                EDIT: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        editing_q <= 1'b0;
                        commit_q  <= 1'b1;
                    end else if (up_rise_c && !down_rise_c) begin
                        inc_pulse_q <= field_onehot(field_sel_q);
                        hold_down_q <= 1'b0;
                        state_q     <= HOLD;
                    end else if (down_rise_c && !up_rise_c) begin
                        dec_pulse_q <= field_onehot(field_sel_q);
                        hold_down_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (!up_rise_c && !down_rise_c) begin
                        // Navigation only counts when no up/down edge is present.
                        if (right_rise_c && !left_rise_c) begin
                            field_sel_q <= (field_sel_q == LAST_FIELD) ? '0 : field_sel_q + SEL_W'(1);
                        end else if (left_rise_c && !right_rise_c) begin
                            field_sel_q <= (field_sel_q == '0) ? LAST_FIELD : field_sel_q - SEL_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        editing_q <= 1'b0;
                        commit_q  <= 1'b1;
                    end else if (!still_held_c) begin
                        state_q <= EDIT;
                    end else if (rpt_fire_c) begin
                        if (hold_down_q) begin
                            dec_pulse_q <= field_onehot(field_sel_q);
                        end else begin
                            inc_pulse_q <= field_onehot(field_sel_q);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    editing_q <= 1'b0;
                end
            endcase
        end
    end

    assign field_sel = field_sel_q;
    assign inc_pulse = inc_pulse_q;
    assign dec_pulse = dec_pulse_q;
    assign editing   = editing_q;
    assign commit    = commit_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
// Bench for rtc_field_editor: directed scenarios plus random button traffic, all
// checked every cycle against a behavioural model of the editor.
// Honours RTC_FIELD_EDIT_AUTOREPEAT_EN the same way the design does.
module tb_rtc_field_editor
    import rtc_edit_pkg::*;
;

    localparam int NF = 9;
    localparam int RD = 4;
    localparam int RP = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [3:0]   field_sel;
    logic [NF-1:0] inc_pulse, dec_pulse;
    logic         editing, commit;

    int checks = 0;
    int errors = 0;

    rtc_field_editor #(
        .NUM_FIELDS   (NF),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .field_sel(field_sel),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .editing  (editing),
        .commit   (commit)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=off, 1=editing, 2=button held.
    int m_mode = 0, m_sel = 0, m_down = 0, m_since = 0, m_rep = 0;
    bit p_u = 0, p_d = 0, p_l = 0, p_r = 0;
    int e_inc = -1, e_dec = -1;
    bit e_commit = 0;

    task automatic model_step();
        bit ru, rd, rl, rr, held;
        e_inc = -1;
        e_dec = -1;
        e_commit = 0;
        if (reset) begin
            m_mode = 0; m_sel = 0; m_since = 0; m_rep = 0;
            p_u = 0; p_d = 0; p_l = 0; p_r = 0;
        end else begin
            ru = btn_up && !p_u;
            rd = btn_down && !p_d;
            rl = btn_left && !p_l;
            rr = btn_right && !p_r;
            held = (m_down != 0) ? btn_down : btn_up;
            case (m_mode)
                0: if (en) begin m_mode = 1; m_sel = 0; end
                1: begin
                    if (!en) begin
                        m_mode = 0; e_commit = 1;
                    end else if (ru || rd) begin
                        if (ru != rd) begin
                            m_down = rd ? 1 : 0;
                            if (rd) e_dec = m_sel; else e_inc = m_sel;
                            m_mode = 2; m_since = 0; m_rep = 0;
                        end
                    end else if (rr && !rl) begin
                        m_sel = (m_sel + 1) % NF;
                    end else if (rl && !rr) begin
                        m_sel = (m_sel + NF - 1) % NF;
                    end
                end
                default: begin
                    if (!en) begin
                        m_mode = 0; e_commit = 1;
                    end else if (!held) begin
                        m_mode = 1;
                    end else begin
`ifdef RTC_FIELD_EDIT_AUTOREPEAT_EN
                        m_since++;
                        if (m_since == ((m_rep != 0) ? RP : RD)) begin
                            if (m_down != 0) e_dec = m_sel; else e_inc = m_sel;
                            m_since = 0;
                            m_rep = 1;
                        end
`endif
                    end
                end
            endcase
            p_u = btn_up; p_d = btn_down; p_l = btn_left; p_r = btn_right;
        end
    endtask

    // One clock: advance the model with the current inputs, then compare just after the edge.
    task automatic tick();
        logic [NF-1:0] xi, xd;
        model_step();
        @(posedge clock);
        #1;
        xi = '0;
        xd = '0;
        if (e_inc >= 0) xi[e_inc] = 1'b1;
        if (e_dec >= 0) xd[e_dec] = 1'b1;
        check("field_sel", 32'(field_sel), 32'(m_sel));
        check("inc_pulse", 32'(inc_pulse), 32'(xi));
        check("dec_pulse", 32'(dec_pulse), 32'(xd));
        check("editing",   32'(editing),   32'(m_mode != 0));
        check("commit",    32'(commit),    32'(e_commit));
    endtask

    task automatic tap_right();
        btn_right = 1'b1; tick();
        btn_right = 1'b0; tick();
    endtask

    task automatic tap_left();
        btn_left = 1'b1; tick();
        btn_left = 1'b0; tick();
    endtask

    initial begin
        int cnt_i, cnt_d;
        logic [15:0] mask;
        logic [15:0] exp_mask;
        logic [NF-1:0] exp_vec;

        // Reset values.
        reset = 1'b1;
        tick(); tick();
        check("rst_sel", 32'(field_sel), 32'd0);
        check("rst_editing", 32'(editing), 32'd0);

        // Enter edit mode, navigate right twice then left three times.
        reset = 1'b0;
        en = 1'b1;
        tick();
        check("enter_editing", 32'(editing), 32'd1);
        tap_right(); tap_right();
        check("sel_after_right", 32'(field_sel), 32'(FLD_HOUR));
        tap_left(); tap_left(); tap_left();
        check("sel_wrap_left", 32'(field_sel), 32'(FLD_TMR_HOUR));
        tap_right(); tap_right(); tap_right(); tap_right();
        check("sel_wrap_right", 32'(field_sel), 32'(FLD_DAY));

        // Up held for five cycles on field 3.
        cnt_i = 0; cnt_d = 0;
        btn_up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (inc_pulse == 9'b000001000) cnt_i++;
            if (dec_pulse != '0) cnt_d++;
        end
        btn_up = 1'b0;
        tick();
`ifdef RTC_FIELD_EDIT_AUTOREPEAT_EN
        check("up_press_inc_count", 32'(cnt_i), 32'd2);
`else
        check("up_press_inc_count", 32'(cnt_i), 32'd1);
`endif
        check("up_press_dec_count", 32'(cnt_d), 32'd0);

        // Up and down rising together: ignored, still navigable afterwards.
        btn_up = 1'b1; btn_down = 1'b1;
        tick();
        check("updown_no_inc", 32'(inc_pulse), 32'd0);
        check("updown_no_dec", 32'(dec_pulse), 32'd0);
        btn_up = 1'b0; btn_down = 1'b0;
        tick();
        tap_right();
        check("updown_stayed_edit", 32'(field_sel), 32'(FLD_MONTH));
        tap_left();

        // Right and up together: up wins, selection unchanged.
        btn_right = 1'b1; btn_up = 1'b1;
        tick();
        exp_vec = '0; exp_vec[FLD_DAY] = 1'b1;
        check("rightup_inc", 32'(inc_pulse), 32'(exp_vec));
        check("rightup_sel", 32'(field_sel), 32'(FLD_DAY));
        btn_right = 1'b0; btn_up = 1'b0;
        tick();

        // Down held for ten cycles on field 0.
        tap_left(); tap_left(); tap_left();
        check("sel_field0", 32'(field_sel), 32'(FLD_SEC));
        mask = '0;
        btn_down = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (dec_pulse[0]) mask[i] = 1'b1;
        end
        btn_down = 1'b0;
        tick();
        tick();
`ifdef RTC_FIELD_EDIT_AUTOREPEAT_EN
        exp_mask = 16'h02A2;
`else
        exp_mask = 16'h0002;
`endif
        check("down_hold_pulse_cycles", 32'(mask), 32'(exp_mask));

        // Drop en while holding up: one commit, no further pulses.
        btn_up = 1'b1;
        tick(); tick();
        en = 1'b0;
        tick();
        check("hold_exit_commit", 32'(commit), 32'd1);
        check("hold_exit_editing", 32'(editing), 32'd0);
        cnt_i = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (inc_pulse != '0 || commit) cnt_i++;
        end
        check("after_commit_quiet", 32'(cnt_i), 32'd0);
        btn_up = 1'b0;

        // Reset while holding down: no commit, no pulse until a fresh edge.
        en = 1'b1;
        tick();
        btn_down = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_hold_commit", 32'(commit), 32'd0);
        check("rst_hold_editing", 32'(editing), 32'd0);
        check("rst_hold_dec", 32'(dec_pulse), 32'd0);
        reset = 1'b0;
        cnt_d = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dec_pulse != '0) cnt_d++;
        end
        check("rst_held_no_pulse", 32'(cnt_d), 32'd0);
        btn_down = 1'b0;
        tick();
        btn_down = 1'b1;
        tick();
        check("rst_fresh_edge_dec", 32'(dec_pulse), 32'd1);
        btn_down = 1'b0;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
            if ($urandom_range(0, 5) == 0) btn_left = ~btn_left;
            if ($urandom_range(0, 5) == 0) btn_right = ~btn_right;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
